adc_sample_ctrl: RTL and testbench
==================================

ADC_SAMPLE_CTRL -- requirements
Module: adc_sample_ctrl

Interface
REQ-001 Parameter SAMPLE_PERIOD, default 20: clk cycles from one adc_req pulse to the next; legal range 4..65535.
REQ-002 Parameter TIMEOUT, default 16: maximum WAIT cycles for adc_rdy before abort; legal range 2..65535.
REQ-003 Parameter AVG_LOG2, default 2: the block averages 2^AVG_LOG2 samples; legal range 0..4.
REQ-004 clk  input  1  single clock; every register updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en  input  1  sampling enable, level-sensitive.
REQ-007 adc_req  output  1  conversion request pulse to the ADC.
REQ-008 adc_rdy  input  1  ADC data-ready level.
REQ-009 adc_dat  input  8  ADC conversion result, unsigned.
REQ-010 sample_valid  output  1  one-cycle strobe qualifying sample_dat.
REQ-011 sample_dat  output  8  last captured raw sample.
REQ-012 avg_valid  output  1  one-cycle strobe qualifying avg_dat.
REQ-013 avg_dat  output  8  truncated mean of the last 2^AVG_LOG2 samples.
REQ-014 timeout_err  output  1  one-cycle strobe on conversion timeout.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, HOLD; all outputs registered.
REQ-017 IDLE with en=1 -> REQ on the next edge; IDLE with en=0 -> stay in IDLE.
REQ-018 REQ lasts exactly one cycle with adc_req=1, clears the period counter, then -> WAIT; adc_req=0 in every other state.
REQ-019 WAIT, first cycle with adc_rdy=1: capture adc_dat into sample_dat, pulse sample_valid on the next cycle, add the sample to the accumulator, -> HOLD.
REQ-020 WAIT, adc_rdy=0 for TIMEOUT consecutive cycles: pulse timeout_err, discard the conversion (no accumulation), -> HOLD.
REQ-021 Period counter counts from entry to REQ; HOLD -> REQ when the count reaches SAMPLE_PERIOD-1 and en=1, so REQ-to-REQ spacing is exactly SAMPLE_PERIOD cycles.
REQ-022 Overrun: if the count has already passed SAMPLE_PERIOD-1 on entry to HOLD, HOLD -> REQ on the next edge; no requests are queued or skipped-counted.
REQ-023 en deasserted in REQ or WAIT: finish the current conversion (capture or timeout), then HOLD -> IDLE; en=0 in HOLD -> IDLE on the next edge.
REQ-024 Accumulator width is 8+AVG_LOG2 bits and cannot overflow.
REQ-025 After 2^AVG_LOG2 accepted samples: avg_dat = acc >> AVG_LOG2 (truncate), avg_valid pulses in the same cycle as the final sample_valid, and the accumulator and sample count clear.
REQ-026 AVG_LOG2=0: avg_dat equals sample_dat and avg_valid coincides with every sample_valid.
REQ-027 Returning to IDLE clears the partial accumulator and sample count; no partial average is emitted.
REQ-028 adc_rdy is ignored outside WAIT.

Reset
REQ-029 rst=1 at an edge forces IDLE; adc_req, sample_valid, avg_valid, timeout_err and busy go to 0; sample_dat, avg_dat, accumulator and all counters go to 0.
REQ-030 rst has priority over en and adc_rdy, aborts any in-flight conversion without a strobe, and first REQ after release is no earlier than one cycle after rst falls.

Structure
REQ-031 Shared package adc_ctrl_pkg holds the FSM state enum, ADC data width constant (8) and counter width constant (16).
REQ-032 Sub-module adc_avg_accum (accumulate, count, divide, strobe) is instantiated once; the FSM and counters stay in adc_sample_ctrl.

Verification
REQ-033 rst 2 cycles, en=1, ADC model raises rdy 3 cycles after req with dat=0x40 -> adc_req pulse spacing exactly 20 cycles; sample_valid with sample_dat=0x40 every 20 cycles.
REQ-034 Samples 10, 20, 30, 41 with AVG_LOG2=2 -> a single avg_valid with avg_dat=25 (101>>2), coincident with the 4th sample_valid.
REQ-035 ADC never raises rdy -> timeout_err pulses 16 cycles after WAIT entry, with no sample_valid and no accumulation; the next req follows 20 cycles after the previous one.
REQ-036 ADC rdy delay 25 cycles (greater than the period) -> next adc_req occurs 1 cycle after HOLD entry; no double request.
REQ-037 en dropped during WAIT -> the pending capture completes with one sample_valid, FSM reaches IDLE, no further adc_req, and busy=0.
REQ-038 rst asserted mid-WAIT after 2 accepted samples -> all outputs are 0 the next cycle; after restart, the first avg_valid requires 4 new samples.

Source files
------------

// File: rtl/adc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_ctrl_pkg
//  Description : Shared definitions for the ADC sampling controller:
//                FSM state encoding, ADC data width, counter width and a
//                saturating-increment helper for the counters.
//  Revision    : 1.0  initial release
// ============================================================================
package adc_ctrl_pkg;

    localparam int C_DATA_W = 8;    // ADC conversion result width
    localparam int C_CNT_W  = 16;   // period / wait counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Increment that sticks at all-ones instead of wrapping, so a long
    // overrun can never alias back below the period threshold.
    function automatic logic [C_CNT_W-1:0] sat_inc(input logic [C_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage : adc_ctrl_pkg
`default_nettype wire

// File: rtl/adc_avg_accum.sv
`default_nettype none
// ============================================================================
//  Module      : adc_avg_accum
//  Description : Accumulates accepted samples and emits the truncated mean
//                of every block of 2^AVG_LOG2 samples.
//  Ports       : clk, rst       - clock / synchronous active-high reset
//                clr            - drop any partial block (no output)
//                in_valid       - in_dat is an accepted sample this cycle
//                in_dat         - sample value
//                avg_valid      - one-cycle strobe, registered
//                avg_dat        - mean of the completed block, registered
//  Revision    : 1.0  initial release
// ============================================================================
module adc_avg_accum
    import adc_ctrl_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                in_valid,
    input  logic [C_DATA_W-1:0] in_dat,
    output logic                avg_valid,
    output logic [C_DATA_W-1:0] avg_dat
);

    // 2^AVG_LOG2 samples of at most 2^C_DATA_W-1 each always fit in this width.
    localparam int ACC_W = C_DATA_W + AVG_LOG2;
    // Sample counter needs at least one bit even when a block is one sample.
    localparam int NUM_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [NUM_W-1:0] C_LAST = NUM_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] r_acc;
    logic [NUM_W-1:0] r_num;
    logic [ACC_W-1:0] w_sum;
    logic             w_last;

    // The final sample is folded in combinationally so the mean comes out on
    // the same edge that registers that sample.
    assign w_sum  = r_acc + ACC_W'(in_dat);
    assign w_last = (r_num == C_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_num     <= '0;
            avg_valid <= 1'b0;
            avg_dat   <= '0;
        end else begin
            avg_valid <= 1'b0;
            if (clr) begin
                r_acc <= '0;
                r_num <= '0;
            end else if (in_valid) begin
                if (w_last) begin
                    r_acc     <= '0;
                    r_num     <= '0;
                    avg_valid <= 1'b1;
                    avg_dat   <= C_DATA_W'(w_sum >> AVG_LOG2);
                end else begin
                    r_acc <= w_sum;
                    r_num <= r_num + 1'b1;
                end
            end
        end
    end

endmodule : adc_avg_accum
`default_nettype wire

// File: rtl/adc_sample_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sample_ctrl
//  Description : Periodic ADC conversion controller. Issues a one-cycle
//                request every SAMPLE_PERIOD cycles while enabled, waits up
//                to TIMEOUT cycles for the ADC ready level, captures the
//                result and feeds a block averager.
//  Ports       : clk, rst       - clock / synchronous active-high reset
//                en             - sampling enable (level)
//                adc_req        - conversion request pulse to the ADC
//                adc_rdy        - ADC data-ready level (used in WAIT only)
//                adc_dat        - ADC conversion result
//                sample_valid   - strobe qualifying sample_dat
//                sample_dat     - last captured raw sample
//                avg_valid      - strobe qualifying avg_dat
//                avg_dat        - truncated mean of the last block
//                timeout_err    - strobe on conversion timeout
//                busy           - FSM not in IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module adc_sample_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 20,
    parameter int TIMEOUT       = 16,
    parameter int AVG_LOG2      = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic                adc_req,
    input  logic                adc_rdy,
    input  logic [C_DATA_W-1:0] adc_dat,
    output logic                sample_valid,
    output logic [C_DATA_W-1:0] sample_dat,
    output logic                avg_valid,
    output logic [C_DATA_W-1:0] avg_dat,
    output logic                timeout_err,
    output logic                busy
);

    localparam logic [C_CNT_W-1:0] C_PERIOD_LAST  = C_CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [C_CNT_W-1:0] C_TIMEOUT_LAST = C_CNT_W'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [C_CNT_W-1:0] r_per_cnt;
    logic [C_CNT_W-1:0] r_wait_cnt;
    logic               w_capture;
    logic               w_timeout;
    logic               w_adc_req;
    logic               w_busy;
    logic               w_sample_valid;
    logic               w_timeout_err;

    // WAIT exit conditions: ready wins over timeout in the same cycle.
    assign w_capture = (r_state == ST_WAIT) && adc_rdy;
    assign w_timeout = (r_state == ST_WAIT) && !adc_rdy &&
                       (r_wait_cnt == C_TIMEOUT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_next = ST_REQ;
                end
            end
            ST_REQ: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                // en is deliberately ignored here: the conversion in flight
                // always completes (capture or timeout) before leaving.
                if (w_capture || w_timeout) begin
                    w_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // ">=" also covers overrun: a conversion that outlasted the
                // period re-requests immediately, without catching up.
                if (!en) begin
                    w_next = ST_IDLE;
                end else if (r_per_cnt >= C_PERIOD_LAST) begin
                    w_next = ST_REQ;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (values registered below so every output is a flop)
    // ------------------------------------------------------------------
    always_comb begin
        w_adc_req      = (w_next == ST_REQ);
        w_busy         = (w_next != ST_IDLE);
        w_sample_valid = w_capture;
        w_timeout_err  = w_timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adc_req      <= 1'b0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            timeout_err  <= 1'b0;
            sample_dat   <= '0;
        end else begin
            adc_req      <= w_adc_req;
            busy         <= w_busy;
            sample_valid <= w_sample_valid;
            timeout_err  <= w_timeout_err;
            if (w_capture) begin
                sample_dat <= adc_dat;
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // The REQ cycle is period count 0, so the register is loaded with 1 as
    // REQ is left; HOLD then sees count k exactly k cycles after REQ.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_per_cnt  <= '0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: r_per_cnt <= '0;
                ST_REQ:  r_per_cnt <= C_CNT_W'(1);
                default: r_per_cnt <= sat_inc(r_per_cnt);
            endcase

            // Counts consecutive not-ready WAIT cycles; exits WAIT before
            // reaching TIMEOUT, so no saturation is needed.
            if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Averager: partial blocks are dropped whenever the FSM is idle.
    // ------------------------------------------------------------------
    adc_avg_accum #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk       (clk),
        .rst       (rst),
        .clr       (r_state == ST_IDLE),
        .in_valid  (w_capture),
        .in_dat    (adc_dat),
        .avg_valid (avg_valid),
        .avg_dat   (avg_dat)
    );

endmodule : adc_sample_ctrl
`default_nettype wire

// File: tb/tb_adc_sample_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_sample_ctrl
//  Description : Directed self-checking bench for adc_sample_ctrl.
//                Instance A uses default parameters; instance B uses a long
//                timeout and AVG_LOG2=0 to exercise overrun and pass-through
//                averaging. Each instance has a small ADC model that raises
//                ready a fixed number of cycles after a request and returns
//                values from a fixed table.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adc_sample_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- instance A (defaults) ----------------
    logic       rst_a, en_a;
    logic       adc_req_a, sample_valid_a, avg_valid_a, timeout_err_a, busy_a;
    logic       adc_rdy_a = 1'b0;
    logic [7:0] adc_dat_a = 8'h00;
    logic [7:0] sample_dat_a, avg_dat_a;
    logic [31:0] outs_a;
    assign outs_a = {11'd0, adc_req_a, sample_valid_a, avg_valid_a, timeout_err_a,
                     busy_a, sample_dat_a, avg_dat_a};

    adc_sample_ctrl u_dut_a (
        .clk          (clk),
        .rst          (rst_a),
        .en           (en_a),
        .adc_req      (adc_req_a),
        .adc_rdy      (adc_rdy_a),
        .adc_dat      (adc_dat_a),
        .sample_valid (sample_valid_a),
        .sample_dat   (sample_dat_a),
        .avg_valid    (avg_valid_a),
        .avg_dat      (avg_dat_a),
        .timeout_err  (timeout_err_a),
        .busy         (busy_a)
    );

    // ---------------- instance B (overrun, no averaging) ----------------
    logic       rst_b, en_b;
    logic       adc_req_b, sample_valid_b, avg_valid_b, timeout_err_b, busy_b;
    logic       adc_rdy_b = 1'b0;
    logic [7:0] adc_dat_b = 8'h00;
    logic [7:0] sample_dat_b, avg_dat_b;

    adc_sample_ctrl #(
        .SAMPLE_PERIOD (20),
        .TIMEOUT       (40),
        .AVG_LOG2      (0)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst_b),
        .en           (en_b),
        .adc_req      (adc_req_b),
        .adc_rdy      (adc_rdy_b),
        .adc_dat      (adc_dat_b),
        .sample_valid (sample_valid_b),
        .sample_dat   (sample_dat_b),
        .avg_valid    (avg_valid_b),
        .avg_dat      (avg_dat_b),
        .timeout_err  (timeout_err_b),
        .busy         (busy_b)
    );

    // ADC A data in order of consumption across all phases
    logic [7:0] tbl_a [24] = '{8'h40, 8'h40, 8'h40, 8'h40, 8'd10, 8'd20, 8'd30, 8'd41,
                               8'd1, 8'd2, 8'd3, 8'd6,
                               8'd77,
                               8'd2, 8'd4, 8'd6, 8'd8,
                               8'd100, 8'd100, 8'd99, 8'd4, 8'd8, 8'd12, 8'd16};
    logic [7:0] tbl_b [3]  = '{8'h5A, 8'hC3, 8'h11};
    int exp_p1 [8] = '{64, 64, 64, 64, 10, 20, 30, 41};
    int exp_p4 [4] = '{4, 8, 12, 16};

    // ---------------- ADC models ----------------
    int rdy_dly_a = 3;      // 0 = never answer
    int cd_a = 0;
    int ptr_a = 0;
    always @(negedge clk) begin
        adc_rdy_a = 1'b0;
        if (cd_a > 0) begin
            cd_a = cd_a - 1;
            if (cd_a == 0) begin
                adc_rdy_a = 1'b1;
                adc_dat_a = (ptr_a < 24) ? tbl_a[ptr_a] : 8'h40;
                ptr_a     = ptr_a + 1;
            end
        end
        if (adc_req_a === 1'b1 && rdy_dly_a > 0) cd_a = rdy_dly_a;
    end

    int cd_b = 0;
    int ptr_b = 0;
    always @(negedge clk) begin
        adc_rdy_b = 1'b0;
        if (cd_b > 0) begin
            cd_b = cd_b - 1;
            if (cd_b == 0) begin
                adc_rdy_b = 1'b1;
                adc_dat_b = (ptr_b < 3) ? tbl_b[ptr_b] : 8'h00;
                ptr_b     = ptr_b + 1;
            end
        end
        if (adc_req_b === 1'b1) cd_b = 25;
    end

    // ---------------- event monitor for A ----------------
    int rq[$], sq[$], sdq[$], aq[$], adq[$], tq[$];
    always @(negedge clk) begin
        if (adc_req_a === 1'b1)      rq.push_back(cyc);
        if (sample_valid_a === 1'b1) begin sq.push_back(cyc); sdq.push_back(int'(sample_dat_a)); end
        if (avg_valid_a === 1'b1)    begin aq.push_back(cyc); adq.push_back(int'(avg_dat_a)); end
        if (timeout_err_a === 1'b1)  tq.push_back(cyc);
    end

    int b_r, b_s, b_a, b_t;
    task automatic mark();
        b_r = rq.size(); b_s = sq.size(); b_a = aq.size(); b_t = tq.size();
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // kind: 0 requests, 1 samples, 2 averages, 3 timeouts (counted since mark)
    task automatic wait_new(input string tag, input int kind, input int n, input int bound);
        int got;
        got = 0;
        for (int i = 0; i < bound; i++) begin
            step(1);
            case (kind)
                0:       got = rq.size() - b_r;
                1:       got = sq.size() - b_s;
                2:       got = aq.size() - b_a;
                default: got = tq.size() - b_t;
            endcase
            if (got >= n) break;
        end
        if (got < n) check_eq({tag, "_wait_expired"}, got, n);
    endtask

    int rel, p, rel4, kb;

    initial begin
        rst_a = 1'b1; en_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0;
        step(2);
        check_eq("reset_outputs", outs_a, 32'd0);

        // ---- phase 1: steady sampling, two average blocks ----
        mark();
        rel  = cyc;
        rst_a = 1'b0;
        en_a  = 1'b1;
        wait_new("p1", 1, 8, 300);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("p1_req_time%0d", i), at(rq, b_r + i), rel + 1 + 20 * i);
            check_eq($sformatf("p1_sv_time%0d", i),  at(sq, b_s + i), rel + 5 + 20 * i);
            check_eq($sformatf("p1_sdat%0d", i),     at(sdq, b_s + i), exp_p1[i]);
        end
        check_eq("p1_avg_count", aq.size() - b_a, 2);
        check_eq("p1_avg0_time", at(aq, b_a), rel + 65);
        check_eq("p1_avg0_dat",  at(adq, b_a), 64);
        check_eq("p1_avg1_time", at(aq, b_a + 1), rel + 145);
        check_eq("p1_avg1_dat",  at(adq, b_a + 1), 25);

        // ---- phase 2: ADC never answers -> timeout ----
        mark();
        rdy_dly_a = 0;
        wait_new("p2_to", 3, 1, 60);
        rdy_dly_a = 3;
        check_eq("p2_req_time",     at(rq, b_r), rel + 161);
        check_eq("p2_timeout_time", at(tq, b_t), rel + 178);
        check_eq("p2_no_sample",    sq.size() - b_s, 0);
        wait_new("p2_smp", 1, 4, 200);
        check_eq("p2_next_req_time", at(rq, b_r + 1), rel + 181);
        check_eq("p2_timeout_count", tq.size() - b_t, 1);
        check_eq("p2_avg_count",     aq.size() - b_a, 1);
        check_eq("p2_avg_time",      at(aq, b_a), rel + 245);
        check_eq("p2_avg_dat",       at(adq, b_a), 3);

        // ---- phase 3: en dropped during WAIT ----
        mark();
        wait_new("p3_req", 0, 1, 40);
        en_a = 1'b0;
        check_eq("p3_busy_in_wait", busy_a, 1);
        step(40);
        check_eq("p3_req_count",  rq.size() - b_r, 1);
        check_eq("p3_req_time",   at(rq, b_r), rel + 261);
        check_eq("p3_sv_count",   sq.size() - b_s, 1);
        check_eq("p3_sv_time",    at(sq, b_s), rel + 265);
        check_eq("p3_sdat",       at(sdq, b_s), 77);
        check_eq("p3_avg_count",  aq.size() - b_a, 0);
        check_eq("p3_busy_idle",  busy_a, 0);

        // ---- phase 3b: restart from IDLE, partial block was dropped ----
        mark();
        p    = cyc;
        en_a = 1'b1;
        wait_new("p3b", 1, 4, 200);
        check_eq("p3b_first_req", at(rq, b_r), p + 1);
        check_eq("p3b_avg_count", aq.size() - b_a, 1);
        check_eq("p3b_avg_time",  at(aq, b_a), p + 65);
        check_eq("p3b_avg_dat",   at(adq, b_a), 5);

        // ---- phase 4: reset mid-WAIT after two accepted samples ----
        mark();
        wait_new("p4_req", 0, 3, 100);
        check_eq("p4_third_req_time", at(rq, b_r + 2), p + 121);
        check_eq("p4_sv_before_rst",  sq.size() - b_s, 2);
        rst_a = 1'b1;
        step(1);
        check_eq("p4_reset_outputs", outs_a, 32'd0);
        mark();
        rel4  = cyc;
        rst_a = 1'b0;
        wait_new("p4_smp", 1, 4, 200);
        check_eq("p4_first_req", at(rq, b_r), rel4 + 1);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("p4_sv_time%0d", i), at(sq, b_s + i), rel4 + 5 + 20 * i);
            check_eq($sformatf("p4_sdat%0d", i),    at(sdq, b_s + i), exp_p4[i]);
        end
        check_eq("p4_avg_count", aq.size() - b_a, 1);
        check_eq("p4_avg_time",  at(aq, b_a), rel4 + 65);
        check_eq("p4_avg_dat",   at(adq, b_a), 10);
        en_a = 1'b0;

        // ---- instance B: conversion longer than the period ----
        kb    = cyc;
        rst_b = 1'b0;
        en_b  = 1'b1;
        step(1);
        check_eq("b_req0",  adc_req_b, 1);
        check_eq("b_busy0", busy_b, 1);
        step(25);
        check_eq("b_sv_early", sample_valid_b, 0);
        step(1);
        check_eq("b_sv1",      sample_valid_b, 1);
        check_eq("b_sdat1",    sample_dat_b, 8'h5A);
        check_eq("b_avgv1",    avg_valid_b, 1);
        check_eq("b_avgd1",    avg_dat_b, 8'h5A);
        check_eq("b_req_hold", adc_req_b, 0);
        step(1);
        check_eq("b_req_overrun", adc_req_b, 1);
        check_eq("b_sv_clear",    sample_valid_b, 0);
        step(1);
        check_eq("b_no_double_req", adc_req_b, 0);
        step(25);
        check_eq("b_sv2",      sample_valid_b, 1);
        check_eq("b_sdat2",    sample_dat_b, 8'hC3);
        check_eq("b_avgv2",    avg_valid_b, 1);
        check_eq("b_avgd2",    avg_dat_b, 8'hC3);
        check_eq("b_no_timeout", timeout_err_b, 0);
        check_eq("b_elapsed",  cyc - kb, 54);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_adc_sample_ctrl
`default_nettype wire
